// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side request and EX-side forwarding response bundle for fwd_hazard_ctrl.
// The master side drives decode info; the slave (the controller) returns the selects and the stall.
interface fwd_hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  logic                  ID_VALID;
  logic [REG_ADDR_W-1:0] ID_RS;
  logic [REG_ADDR_W-1:0] ID_RT;
  logic                  ID_USE_RS;
  logic                  ID_USE_RT;
  logic [REG_ADDR_W-1:0] ID_DST;
  logic                  ID_REG_WRITE;
  logic                  ID_MEM_READ;
  logic                  FLUSH_ID;
  logic                  FREEZE;
  logic                  LOAD_USE_STALL;
  logic [1:0]            FWD_A_SEL;
  logic [1:0]            FWD_B_SEL;
  logic                  EX_VALID;

  modport master (
    output ID_VALID, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT, ID_DST,
           ID_REG_WRITE, ID_MEM_READ, FLUSH_ID, FREEZE,
    input  LOAD_USE_STALL, FWD_A_SEL, FWD_B_SEL, EX_VALID
  );

  modport slave (
    input  ID_VALID, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT, ID_DST,
           ID_REG_WRITE, ID_MEM_READ, FLUSH_ID, FREEZE,
    output LOAD_USE_STALL, FWD_A_SEL, FWD_B_SEL, EX_VALID
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller: shadows EX/MEM/WB destinations and emits EX-aligned mux selects.
// Define RF_BYPASS_EN to add a RET shadow stage and the 11 retired-result bypass select.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 0
) (
  input logic CLK,
  input logic RST,
  fwd_hazard_ctrl_if.slave bus
);
  typedef logic [REG_ADDR_W-1:0] reg_t;
  typedef struct packed {
    logic valid;
    reg_t dst;
    logic reg_write;
    logic mem_read;
  } stage_t;

  localparam reg_t   ZERO   = reg_t'(ZERO_REG);
  localparam stage_t BUBBLE = '0;

  stage_t     ex_q, mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] sel_a, sel_b;
  logic       hazard, take;
  stage_t     id_info;

  function automatic logic writes(stage_t s, reg_t r);
    return s.valid && s.reg_write && (s.dst == r) && (s.dst != ZERO);
  endfunction

  // EX holds the instruction that will be in MEM when the consumer reaches EX, hence 10;
  // a load there cannot forward yet and is handled by the stall instead.
  function automatic logic [1:0] pick(logic used, reg_t r, stage_t ex, stage_t mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (writes(ex, r) && !ex.mem_read) sel = 2'b10;
      else if (writes(mem, r))           sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    hazard = bus.ID_VALID && !bus.FLUSH_ID && ex_q.mem_read &&
             ((bus.ID_USE_RS && writes(ex_q, bus.ID_RS)) ||
              (bus.ID_USE_RT && writes(ex_q, bus.ID_RT)));
    take   = bus.ID_VALID && !bus.FLUSH_ID && !hazard;
    sel_a  = pick(bus.ID_USE_RS, bus.ID_RS, ex_q, mem_q);
    sel_b  = pick(bus.ID_USE_RT, bus.ID_RT, ex_q, mem_q);
`ifdef RF_BYPASS_EN
    // Value retiring now is gone from the WB mux by the time the consumer reaches EX.
    if (bus.ID_USE_RS && sel_a == 2'b00 && writes(wb_q, bus.ID_RS)) sel_a = 2'b11;
    if (bus.ID_USE_RT && sel_b == 2'b00 && writes(wb_q, bus.ID_RT)) sel_b = 2'b11;
`endif
    id_info = '{valid: 1'b1, dst: bus.ID_DST, reg_write: bus.ID_REG_WRITE,
                mem_read: bus.ID_MEM_READ};
  end

`ifdef RF_BYPASS_EN
  stage_t ret_q;
  logic   unused_ret;
  assign unused_ret = ^ret_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             ret_q <= BUBBLE;
    else if (!bus.FREEZE) ret_q <= wb_q;
  end
`else
  logic unused_wb;
  assign unused_wb = ^wb_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!bus.FREEZE) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (take) begin
        ex_q    <= id_info;
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end else begin
        ex_q    <= BUBBLE;
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end
    end
  end

  assign bus.LOAD_USE_STALL = hazard;
  assign bus.FWD_A_SEL      = fwd_a_q;
  assign bus.FWD_B_SEL      = fwd_b_q;
  assign bus.EX_VALID       = ex_q.valid;
endmodule
